muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the pipeline's execute stage. It decodes the M-extension `funct3` and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a parametrised operand width. A valid/ready start handshake and a one-cycle `done_o` pulse let the hazard unit stall the pipeline while the unit is busy. Divide-by-zero finishes early; `flush_i` aborts an operation in flight.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_decode.sv | 51 +++++
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 encodings and the FSM state type.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Start/result bundle between the execute stage and the multiply/divide unit.
// Handshake: a start is taken on a rising edge where valid_i & ready_o; done_o is
// a one-cycle pulse and result_o/tag_o hold until the next done_o.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  op_a_i;
  logic [XLEN-1:0]  op_b_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             done_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output valid_i, funct3_i, op_a_i, op_b_i, tag_i, flush_i,
    input  ready_o, done_o, result_o, tag_o
  );

  modport slave (
    input  valid_i, funct3_i, op_a_i, op_b_i, tag_i, flush_i,
    output ready_o, done_o, result_o, tag_o
  );
endinterface

// File: rtl/muldiv_decode.sv
// Combinational funct3 decode into the control fields the datapath needs.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [2:0] funct3_i,
  output logic       is_div_o,
  output logic       want_rem_o,
  output logic       want_high_o,
  output logic       a_signed_o,
  output logic       b_signed_o
);

  always_comb begin
    is_div_o    = 1'b0;
    want_rem_o  = 1'b0;
    want_high_o = 1'b0;
    a_signed_o  = 1'b0;
    b_signed_o  = 1'b0;
    case (funct3_i)
      F3_MUL: ;
      F3_MULH: begin
        want_high_o = 1'b1;
        a_signed_o  = 1'b1;
        b_signed_o  = 1'b1;
      end
      F3_MULHSU: begin
        want_high_o = 1'b1;
        a_signed_o  = 1'b1;
      end
      F3_MULHU: want_high_o = 1'b1;
      F3_DIV: begin
        is_div_o   = 1'b1;
        a_signed_o = 1'b1;
        b_signed_o = 1'b1;
      end
      F3_DIVU: is_div_o = 1'b1;
      F3_REM: begin
        is_div_o   = 1'b1;
        want_rem_o = 1'b1;
        a_signed_o = 1'b1;
        b_signed_o = 1'b1;
      end
      F3_REMU: begin
        is_div_o   = 1'b1;
        want_rem_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign applied in a single fix-up cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus,
  output state_e   state_o
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              want_rem_q, want_rem_d;
  logic              want_high_q, want_high_d;
  logic              neg_q, neg_d;
  logic [TAG_W-1:0]  tag_lat_q, tag_lat_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              done_q, done_d;

  logic dec_is_div, dec_want_rem, dec_want_high, dec_a_signed, dec_b_signed;

  muldiv_decode u_decode (
    .funct3_i    (bus.funct3_i),
    .is_div_o    (dec_is_div),
    .want_rem_o  (dec_want_rem),
    .want_high_o (dec_want_high),
    .a_signed_o  (dec_a_signed),
    .b_signed_o  (dec_b_signed)
  );

  // Operand magnitudes; negating the most negative value wraps to 2^(XLEN-1),
  // which is exactly the unsigned magnitude wanted.
  logic            neg_a, neg_b, accept, div_zero;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    neg_a    = dec_a_signed & bus.op_a_i[XLEN-1];
    neg_b    = dec_b_signed & bus.op_b_i[XLEN-1];
    mag_a    = neg_a ? (~bus.op_a_i + 1'b1) : bus.op_a_i;
    mag_b    = neg_b ? (~bus.op_b_i + 1'b1) : bus.op_b_i;
    accept   = bus.valid_i & (state_q == S_IDLE) & ~bus.flush_i;
    div_zero = dec_is_div & (bus.op_b_i == '0);
  end

  // Per-cycle datapath steps and the sign fix-up.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_sub;
  logic              div_bit;
  logic [2*XLEN-1:0] full_prod;
  logic [XLEN-1:0]   div_val, div_res, fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_bit   = (div_shift >= {1'b0, opnd_q});
    div_sub   = div_shift[XLEN-1:0] - opnd_q;
    full_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    div_val   = want_rem_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_res   = neg_q ? (~div_val + 1'b1) : div_val;
    if (is_div_q) begin
      fix_res = div_res;
    end else if (want_high_q) begin
      fix_res = full_prod[2*XLEN-1:XLEN];
    end else begin
      fix_res = full_prod[XLEN-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    is_div_d    = is_div_q;
    want_rem_d  = want_rem_q;
    want_high_d = want_high_q;
    neg_d       = neg_q;
    tag_lat_d   = tag_lat_q;
    result_d    = result_q;
    tag_d       = tag_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d    = dec_is_div;
          want_rem_d  = dec_want_rem;
          want_high_d = dec_want_high;
          neg_d       = (dec_is_div & dec_want_rem) ? neg_a : (neg_a ^ neg_b);
          tag_lat_d   = bus.tag_i;
          cnt_d       = '0;
          if (div_zero) begin
            result_d = dec_want_rem ? bus.op_a_i : '1;
            tag_d    = bus.tag_i;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (dec_is_div ? mag_a : mag_b)};
            opnd_d  = dec_is_div ? mag_b : mag_a;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_d = {(div_bit ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_bit};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        tag_d    = tag_lat_q;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort keeps the previously published result untouched.
    if (bus.flush_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      result_d = result_q;
      tag_d    = tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      is_div_q    <= 1'b0;
      want_rem_q  <= 1'b0;
      want_high_q <= 1'b0;
      neg_q       <= 1'b0;
      tag_lat_q   <= '0;
      result_q    <= '0;
      tag_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      is_div_q    <= is_div_d;
      want_rem_q  <= want_rem_d;
      want_high_q <= want_high_d;
      neg_q       <= neg_d;
      tag_lat_q   <= tag_lat_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      done_q      <= done_d;
    end
  end

  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.tag_o    = tag_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit: results against a reference model,
// done/ready timing, divide-by-zero early exit, flush and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic   clk;
  logic   rst_n;
  state_e state_dbg;

  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int              n_cmp  = 0;
  int              n_fail = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int              exp_lat_q[$];
  logic [XLEN-1:0] last_res;

  task automatic check(input string name, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [2:0] f3,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [2*XLEN-1:0] sa, sb, zb, p;
    logic [2*XLEN-1:0]        ua, ub, up;
    logic signed [XLEN-1:0]   qa, qb;
    logic                     ovf;
    sa  = {{XLEN{a[XLEN-1]}}, a};
    sb  = {{XLEN{b[XLEN-1]}}, b};
    zb  = {{XLEN{1'b0}}, b};
    ua  = {{XLEN{1'b0}}, a};
    ub  = {{XLEN{1'b0}}, b};
    qa  = a;
    qb  = b;
    ovf = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    model = '0;
    case (f3)
      F3_MUL:    begin up = ua * ub; model = up[XLEN-1:0]; end
      F3_MULH:   begin p = sa * sb;  model = p[2*XLEN-1:XLEN]; end
      F3_MULHSU: begin p = sa * zb;  model = p[2*XLEN-1:XLEN]; end
      F3_MULHU:  begin up = ua * ub; model = up[2*XLEN-1:XLEN]; end
      F3_DIV:    model = (b == '0) ? '1 : (ovf ? a : XLEN'(qa / qb));
      F3_DIVU:   model = (b == '0) ? '1 : a / b;
      F3_REM:    model = (b == '0) ? a  : (ovf ? '0 : XLEN'(qa % qb));
      F3_REMU:   model = (b == '0) ? a  : a % b;
      default:   model = '0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tg);
    check("ready_before_start", XLEN'(bus.ready_o), 1);
    bus.valid_i  = 1'b1;
    bus.funct3_i = f3;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    bus.tag_i    = tg;
    exp_q.push_back(model(f3, a, b));
    exp_tag_q.push_back(tg);
    exp_lat_q.push_back((f3[2] && b == '0) ? 0 : XLEN + 1);
    step();
    bus.valid_i = 1'b0;
  endtask

  // Called right after start(): counts cycles after the accept edge until done_o.
  task automatic wait_done(input string name);
    int               lat;
    int               ready_hi;
    bit               seen;
    logic [XLEN-1:0]  e;
    logic [TAG_W-1:0] et;
    int               el;
    lat = 0; ready_hi = 0; seen = 1'b0;
    for (int k = 0; k <= XLEN + 8; k++) begin
      if (bus.ready_o) ready_hi++;
      if (bus.done_o) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      step();
    end
    e  = exp_q.pop_front();
    et = exp_tag_q.pop_front();
    el = exp_lat_q.pop_front();
    check({name, "_done_seen"}, XLEN'(seen), 1);
    if (seen) begin
      check({name, "_latency"}, XLEN'(lat), XLEN'(el));
      check({name, "_result"}, bus.result_o, e);
      check({name, "_tag"}, XLEN'(bus.tag_o), XLEN'(et));
      check({name, "_ready_low_while_busy"}, XLEN'(ready_hi), 0);
      last_res = e;
      step();
      check({name, "_done_one_cycle"}, XLEN'(bus.done_o), 0);
      check({name, "_ready_after"}, XLEN'(bus.ready_o), 1);
      check({name, "_result_held"}, bus.result_o, e);
    end
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done_o) cnt++;
      step();
    end
    check(name, XLEN'(cnt), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n        = 1'b0;
    bus.valid_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.funct3_i = '0;
    bus.op_a_i   = '0;
    bus.op_b_i   = '0;
    bus.tag_i    = '0;
    last_res     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("reset_ready", XLEN'(bus.ready_o), 1);
    check("reset_done", XLEN'(bus.done_o), 0);
    check("reset_result", bus.result_o, 0);
    check("reset_tag", XLEN'(bus.tag_o), 0);
    check("reset_state", XLEN'(state_dbg), XLEN'(S_IDLE));

    start(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1);       wait_done("mul_7_m3");
    start(F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2); wait_done("mulh_min");
    start(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3); wait_done("mulhu_max");
    start(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4); wait_done("mulhsu_m1");
    start(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);       wait_done("div_m7_2");
    start(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);       wait_done("rem_m7_2");
    start(F3_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd7);      wait_done("divu_big");
    start(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8); wait_done("div_ovf");
    start(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9); wait_done("rem_ovf");
    start(F3_DIV, 32'd5, 32'd0, 5'd10);              wait_done("div_by_zero");
    start(F3_REMU, 32'd5, 32'd0, 5'd11);             wait_done("remu_by_zero");

    // Back-to-back tagged MUL then DIV, the second accepted at the first IDLE cycle.
    start(F3_MUL, 32'h0001_2345, 32'h0000_0100, 5'd3); wait_done("b2b_mul");
    start(F3_DIV, 32'hFFFF_FF00, 32'd16, 5'd9);       wait_done("b2b_div");

    // Flush in flight at N+10.
    start(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12);
    void'(exp_q.pop_back());
    void'(exp_tag_q.pop_back());
    void'(exp_lat_q.pop_back());
    repeat (9) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("flush_ready", XLEN'(bus.ready_o), 1);
    check("flush_done", XLEN'(bus.done_o), 0);
    check("flush_result_kept", bus.result_o, last_res);
    check("flush_tag_kept", XLEN'(bus.tag_o), 9);
    watch_no_done("flush_no_done", XLEN + 6);

    // Flush together with valid in IDLE: nothing may be accepted.
    bus.valid_i  = 1'b1;
    bus.flush_i  = 1'b1;
    bus.funct3_i = F3_DIV;
    bus.op_a_i   = 32'd77;
    bus.op_b_i   = 32'd0;
    bus.tag_i    = 5'd20;
    step();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flush_valid_ready", XLEN'(bus.ready_o), 1);
    check("flush_valid_done", XLEN'(bus.done_o), 0);
    watch_no_done("flush_valid_no_done", 6);
    check("flush_valid_result_kept", bus.result_o, last_res);

    // Random operations scored against the reference model.
    for (int i = 0; i < 10; i++) begin
      logic [2:0]      f3;
      logic [XLEN-1:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
      start(f3, a, b, TAG_W'(i + 13));
      wait_done($sformatf("rand%0d_f3_%0d", i, f3));
    end

    // Reset at N+5 in the middle of a divide.
    start(F3_DIV, 32'd1000, 32'd7, 5'd30);
    void'(exp_q.pop_back());
    void'(exp_tag_q.pop_back());
    void'(exp_lat_q.pop_back());
    repeat (4) step();
    rst_n       = 1'b0;
    bus.valid_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
    rst_n       = 1'b1;
    check("rst_mid_ready", XLEN'(bus.ready_o), 1);
    check("rst_mid_done", XLEN'(bus.done_o), 0);
    check("rst_mid_result", bus.result_o, 0);
    check("rst_mid_tag", XLEN'(bus.tag_o), 0);
    watch_no_done("rst_mid_no_stale_done", XLEN + 6);

    // Unit must still work after the abort.
    start(F3_REMU, 32'd1000, 32'd7, 5'd31); wait_done("after_reset_remu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
